// File: rtl/opimm_unit_if.sv
// opimm_unit_if -- handshake bundle for the OP-IMM execution unit.
//   Request side : in_valid, in_ready, instr[31:0], rs1_value[XLEN-1:0]
//   Response side: out_valid, out_ready, result[XLEN-1:0], rd[4:0], wr_en, illegal
//   master modport: the producer/consumer around the unit (drives in_* and out_ready)
//   slave modport : the unit itself
interface opimm_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_value;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd;
  logic            wr_en;
  logic            illegal;

  modport master (
    output in_valid, instr, rs1_value, out_ready,
    input  in_ready, out_valid, result, rd, wr_en, illegal
  );

  modport slave (
    input  in_valid, instr, rs1_value, out_ready,
    output in_ready, out_valid, result, rd, wr_en, illegal
  );
endinterface

// File: rtl/opimm_unit.sv
// opimm_unit -- executes one RISC-V OP-IMM instruction at a time.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : opimm_unit_if.slave
//     in_valid/in_ready/instr/rs1_value   -- operation request
//     out_valid/out_ready                 -- result handshake
//     result/rd/wr_en/illegal             -- held stable while out_valid && !out_ready
// Non-shift ops complete in one cycle. Shifts are iterative: SHIFT_STEP bit
// positions per cycle, so a shift of shamt takes 1+ceil(shamt/SHIFT_STEP) cycles.
module opimm_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  opimm_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_result, w_result_next;
  logic [4:0]      r_rd, w_rd_next;
  logic            r_wr_en, w_wr_en_next;
  logic            r_illegal, w_illegal_next;
  logic [6:0]      r_remaining, w_remaining_next;
  logic            r_left, w_left_next;
  logic            r_arith, w_arith_next;

  // ---------------- decode of the presented instruction ----------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;
  logic [6:0]      w_shamt;
  logic            w_sll_bad;
  logic            w_sr_bad;
  logic            w_is_shift;
  logic            w_illegal;
  logic [XLEN-1:0] w_alu;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_rd     = bus.instr[11:7];
  assign w_imm    = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};

  // The shamt field widens by one bit on RV64; the remaining upper bits must
  // be zero, except instr[30] which selects arithmetic right shift.
  generate
    if (XLEN == 64) begin : g_rv64
      assign w_shamt   = {1'b0, bus.instr[25:20]};
      assign w_sll_bad = |bus.instr[31:26];
      assign w_sr_bad  = bus.instr[31] | (|bus.instr[29:26]);
    end else begin : g_rv32
      assign w_shamt   = {2'b00, bus.instr[24:20]};
      assign w_sll_bad = |bus.instr[31:25];
      assign w_sr_bad  = bus.instr[31] | (|bus.instr[29:25]);
    end
  endgenerate

  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_illegal  = (w_opcode != 7'b0010011)
                    || ((w_funct3 == 3'b001) && w_sll_bad)
                    || ((w_funct3 == 3'b101) && w_sr_bad);

  always_comb begin
    w_alu = bus.rs1_value;  // shifts by zero pass rs1 through
    case (w_funct3)
      3'b000: w_alu = bus.rs1_value + w_imm;
      3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.rs1_value) < $signed(w_imm))};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, (bus.rs1_value < w_imm)};
      3'b100: w_alu = bus.rs1_value ^ w_imm;
      3'b110: w_alu = bus.rs1_value | w_imm;
      3'b111: w_alu = bus.rs1_value & w_imm;
      default: w_alu = bus.rs1_value;
    endcase
  end

  // ---------------- handshake ----------------
  logic w_in_ready;
  logic w_accept;

  // A result leaving DONE frees the unit in the same cycle (back-to-back issue).
  assign w_in_ready = reset && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;

  // ---------------- iterative shifter ----------------
  logic [6:0]      w_step;
  logic [XLEN-1:0] w_shifted;

  assign w_step = (r_remaining < STEP) ? r_remaining : STEP;

  always_comb begin
    if (r_left)
      w_shifted = r_result << w_step;
    else if (r_arith)
      w_shifted = XLEN'($signed(r_result) >>> w_step);  // replicates the captured sign bit
    else
      w_shifted = r_result >> w_step;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_next     = r_state;
    w_result_next    = r_result;
    w_rd_next        = r_rd;
    w_wr_en_next     = r_wr_en;
    w_illegal_next   = r_illegal;
    w_remaining_next = r_remaining;
    w_left_next      = r_left;
    w_arith_next     = r_arith;

    case (r_state)
      SHIFT: begin
        w_result_next    = w_shifted;
        w_remaining_next = r_remaining - w_step;
        if (r_remaining == w_step)
          w_state_next = DONE;
      end
      default: begin  // IDLE, or DONE waiting on out_ready
        if ((r_state == DONE) && bus.out_ready)
          w_state_next = IDLE;
        if (w_accept) begin
          w_rd_next        = w_rd;
          w_illegal_next   = w_illegal;
          w_wr_en_next     = !w_illegal && (w_rd != 5'd0);
          w_left_next      = (w_funct3 == 3'b001);
          w_arith_next     = bus.instr[30];
          w_remaining_next = w_shamt;
          if (w_illegal) begin
            w_result_next = '0;
            w_state_next  = DONE;
          end else if (w_is_shift && (w_shamt != 7'd0)) begin
            w_result_next = bus.rs1_value;
            w_state_next  = SHIFT;
          end else begin
            w_result_next = w_alu;
            w_state_next  = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_rd        <= '0;
      r_wr_en     <= 1'b0;
      r_illegal   <= 1'b0;
      r_remaining <= '0;
      r_left      <= 1'b0;
      r_arith     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_result    <= w_result_next;
      r_rd        <= w_rd_next;
      r_wr_en     <= w_wr_en_next;
      r_illegal   <= w_illegal_next;
      r_remaining <= w_remaining_next;
      r_left      <= w_left_next;
      r_arith     <= w_arith_next;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = reset && (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.rd        = r_rd;
  assign bus.wr_en     = r_wr_en;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_opimm_unit.sv
// tb_opimm_unit -- scoreboard bench for opimm_unit (XLEN 32).
// Stimulus pushes expected responses computed by a reference model; a monitor
// pops and compares whenever out_valid is presented. A second instance with
// SHIFT_STEP 8 is used for a directed latency check.
module tb_opimm_unit;
  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  opimm_unit_if #(.XLEN(XLEN)) bus();
  opimm_unit_if #(.XLEN(XLEN)) bus8();

  opimm_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut  (.clk(clk), .reset(reset), .bus(bus));
  opimm_unit #(.XLEN(XLEN), .SHIFT_STEP(8))    dut8 (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [31:0] ins;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_txn = 0;
  logic ready_force_en  = 1'b1;
  logic ready_force_val = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: OP-IMM semantics from the ISA rules, plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a);
    exp_t        e;
    logic [31:0] imm;
    int          sh;
    bit          ill;
    logic [31:0] r;
    imm = {{20{ins[31]}}, ins[31:20]};
    sh  = int'(ins[24:20]);
    ill = 0;
    r   = 32'd0;
    e.lat = 1;
    if (ins[6:0] != 7'h13) ill = 1;
    else begin
      case (ins[14:12])
        3'd0: r = a + imm;
        3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: r = (a < imm) ? 32'd1 : 32'd0;
        3'd4: r = a ^ imm;
        3'd6: r = a | imm;
        3'd7: r = a & imm;
        3'd1: begin
          if (ins[31:25] != 7'd0) ill = 1;
          else begin
            r = a << sh;
            e.lat = 1 + (sh + STEP - 1) / STEP;
          end
        end
        default: begin  // 3'd5
          if (ins[31] || (ins[29:25] != 5'd0)) ill = 1;
          else begin
            r = a >> sh;
            if (ins[30] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            e.lat = 1 + (sh + STEP - 1) / STEP;
          end
        end
      endcase
    end
    if (ill) begin
      r = 32'd0;
      e.lat = 1;
    end
    e.ins = ins;
    e.res = r;
    e.rd  = ins[11:7];
    e.ill = ill;
    e.we  = !ill && (ins[11:7] != 5'd0);
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [2:0] f3,
                                      input logic [4:0] rdv, input logic [6:0] opc);
    return {imm, 5'd1, f3, rdv, opc};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  opc;
    logic [6:0]  hi;
    logic [4:0]  sh;
    logic [4:0]  rdv;
    logic [2:0]  f3;
    logic [11:0] imm;
    f3  = 3'($urandom_range(0, 7));
    rdv = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    opc = ($urandom_range(0, 11) == 0) ? 7'($urandom) : 7'h13;
    imm = 12'($urandom);
    if (f3 == 3'd1 || f3 == 3'd5) begin
      sh = 5'($urandom);
      if ($urandom_range(0, 5) == 0) hi = 7'($urandom);
      else hi = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      imm = {hi, sh};
    end
    return {imm, 5'($urandom), f3, rdv, opc};
  endfunction

  function automatic logic [31:0] gen_rs1();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000 | $urandom;
      1:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present one request; returns the number of cycles it waited for in_ready.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, output int waits);
    exp_t e;
    bit   done;
    done = 0;
    waits = 0;
    bus.in_valid  = 1'b1;
    bus.instr     = ins;
    bus.rs1_value = a;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(ins, a);
        e.acc = cyc + 1;
        sb.push_back(e);
        done = 1;
      end else begin
        waits++;
        if (waits > 500) begin
          n_cmp++;
          n_bad++;
          $display("FAIL issue_timeout: in_ready stuck at 0, expected 1");
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || have_cur) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    #1;
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = ready_force_en ? ready_force_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard checker
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got result %0h, expected no output", bus.result);
          end else begin
            cur = sb.pop_front();
            have_cur = 1;
            n_txn++;
            check("result",  bus.result, cur.res);
            check("rd",      32'(bus.rd), 32'(cur.rd));
            check("wr_en",   32'(bus.wr_en), 32'(cur.we));
            check("illegal", 32'(bus.illegal), 32'(cur.ill));
            check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
            $display("txn %0d: instr=%h result=%h rd=%0d wr_en=%b illegal=%b latency=%0d",
                     n_txn, cur.ins, bus.result, bus.rd, bus.wr_en, bus.illegal, cyc - cur.acc + 1);
          end
        end else begin
          check("hold_result", bus.result, cur.res);
          check("hold_rd",     32'(bus.rd), 32'(cur.rd));
          check("hold_flags",  32'({bus.wr_en, bus.illegal}), 32'({cur.we, cur.ill}));
        end
        check("in_ready_done", 32'(bus.in_ready), 32'(bus.out_ready));
        if (bus.out_ready) have_cur = 0;
      end
    end
  end

  initial begin
    int w;
    int n;
    int highs;
    bus.in_valid   = 1'b0;
    bus.instr      = 32'd0;
    bus.rs1_value  = 32'd0;
    bus8.in_valid  = 1'b0;
    bus8.instr     = 32'd0;
    bus8.rs1_value = 32'd0;
    bus8.out_ready = 1'b1;
    reset = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result, 32'd0);
    check("rst_rd",        32'(bus.rd), 32'd0);
    check("rst_flags",     32'({bus.wr_en, bus.illegal}), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed operations
    issue(enc(12'd3, 3'd0, 5'd5, 7'h13), 32'd0, w);
    issue(enc(12'd4, 3'd0, 5'd9, 7'h13), 32'd3, w);
    issue(enc(12'hFFF, 3'd0, 5'd2, 7'h13), 32'd0, w);
    issue(enc(12'hFFF, 3'd3, 5'd2, 7'h13), 32'd5, w);
    issue(enc(12'hFFF, 3'd2, 5'd2, 7'h13), 32'd5, w);
    issue(enc(12'h41F, 3'd5, 5'd7, 7'h13), 32'h8000_0000, w);
    issue(enc(12'h01F, 3'd5, 5'd7, 7'h13), 32'h8000_0000, w);
    issue(enc(12'h00A, 3'd1, 5'd8, 7'h13), 32'h0000_0123, w);
    issue(enc(12'h400, 3'd5, 5'd8, 7'h13), 32'hF000_0000, w);
    issue(enc(12'd5, 3'd0, 5'd3, 7'h33), 32'd9, w);
    issue(enc(12'h023, 3'd1, 5'd3, 7'h13), 32'd9, w);
    issue(enc(12'h07F, 3'd0, 5'd0, 7'h13), 32'd1, w);
    drain();

    // Hold result 3 cycles, then release with a simultaneous new request
    ready_force_val = 1'b0;
    issue(enc(12'd17, 3'd0, 5'd4, 7'h13), 32'd100, w);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", 32'(bus.out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1 ready_force_val = 1'b1;
    issue(enc(12'h0F0, 3'd6, 5'd6, 7'h13), 32'h0000_000F, w);
    check("b2b_accept_waits", 32'(w), 32'd0);
    drain();

    // Reset in the middle of a shift abandons it
    issue(enc(12'h00A, 3'd1, 5'd3, 7'h13), 32'h0000_0001, w);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    have_cur = 0;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    highs = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) highs++;
    end
    check("no_out_after_reset", 32'(highs), 32'd0);
    @(posedge clk);
    #1;
    issue(enc(12'd21, 3'd0, 5'd11, 7'h13), 32'd21, w);
    drain();

    // Randomized traffic with random backpressure
    ready_force_en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      issue(gen_instr(), gen_rs1(), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_force_en  = 1'b1;
    ready_force_val = 1'b1;
    drain();

    // SHIFT_STEP 8: SRAI 31 on 0x80000000 completes 5 cycles after accept
    bus8.instr     = enc(12'h41F, 3'd5, 5'd7, 7'h13);
    bus8.rs1_value = 32'h8000_0000;
    bus8.in_valid  = 1'b1;
    @(negedge clk);
    check("step8_in_ready", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.out_valid && n < 50);
    check("step8_latency", 32'(n), 32'd5);
    check("step8_result",  bus8.result, 32'hFFFF_FFFF);
    check("step8_wr_en",   32'(bus8.wr_en), 32'd1);
    $display("txn step8: instr=%h result=%h latency=%0d", bus8.instr, bus8.result, n);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
